// File: rtl/tap_tempo_detector.sv
// Tap-tempo detector: synchronizes and debounces a tap input, measures beat
// intervals, tracks a running-average period and shows the beat index on a 7-segment digit.
module tap_tempo_detector #(
  parameter int unsigned CLK_HZ          = 27000000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned MIN_PERIOD      = 6750000,
  parameter int unsigned MAX_PERIOD      = 54000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tap_in,
  output logic        tap_pulse,
  output logic [31:0] period_out,
  output logic        period_valid,
  output logic        locked,
  output logic [3:0]  beat_num,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g
);

  localparam int unsigned DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] MIN_L    = 32'(MIN_PERIOD);
  localparam logic [31:0] MAX_L    = 32'(MAX_PERIOD);
  localparam logic [31:0] SAT_L    = 32'(MAX_PERIOD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             tap_pulse_q, tap_pulse_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic             valid_q, valid_d;
  logic [3:0]       beat_q, beat_d;
  logic [6:0]       seg_q, seg_d;
  logic             locked_q, locked_d;
  logic [31:0]      interval_s;
  logic [32:0]      sum_s;
  logic             unused_clk_hz_s;

  assign unused_clk_hz_s = (CLK_HZ != 32'd0);

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d       = deb_q;
    deb_cnt_d   = {DEB_W{1'b0}};
    tap_pulse_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d       = sync2_q;
        tap_pulse_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_d = {DEB_W{1'b0}};
    end
  end

  // Tempo FSM; the counter holds (elapsed cycles - 1) since the last clearing tap.
  always_comb begin
    interval_s = cnt_q + 32'd1;
    sum_s      = {1'b0, period_q} + {1'b0, interval_s};
    state_d    = state_q;
    cnt_d      = (cnt_q == SAT_L) ? cnt_q : cnt_q + 32'd1;
    period_d   = period_q;
    valid_d    = 1'b0;
    beat_d     = beat_q;
    case (state_q)
      S_IDLE: begin
        if (tap_pulse_q) begin
          state_d = S_ARMED;
          beat_d  = 4'd1;
          cnt_d   = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED, S_TRACK: begin
        if (tap_pulse_q) begin
          if (interval_s < MIN_L) begin
            state_d = state_q;
          end else if (interval_s <= MAX_L) begin
            state_d  = S_TRACK;
            period_d = (state_q == S_TRACK) ? sum_s[32:1] : interval_s;
            valid_d  = 1'b1;
            beat_d   = (beat_q >= 4'd8) ? 4'd1 : beat_q + 4'd1;
            cnt_d    = 32'd0;
          end else begin
            state_d = S_ARMED;
            beat_d  = 4'd1;
            cnt_d   = 32'd0;
          end
        end else if (cnt_q == SAT_L) begin
          state_d = S_IDLE;
          beat_d  = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 4'd0;
      end
    endcase
    seg_d    = seg_of(beat_d);
    locked_d = (state_d == S_TRACK);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= {DEB_W{1'b0}};
      tap_pulse_q <= 1'b0;
      cnt_q       <= 32'd0;
      state_q     <= S_IDLE;
      period_q    <= 32'd0;
      valid_q     <= 1'b0;
      beat_q      <= 4'd0;
      seg_q       <= 7'b0000000;
      locked_q    <= 1'b0;
    end else begin
      sync1_q     <= tap_in;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      tap_pulse_q <= tap_pulse_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      seg_q       <= seg_d;
      locked_q    <= locked_d;
    end
  end

  assign tap_pulse             = tap_pulse_q;
  assign period_out            = period_q;
  assign period_valid          = valid_q;
  assign locked                = locked_q;
  assign beat_num              = beat_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_tap_tempo_detector.sv
// Self-checking bench: taps are scheduled as cycle intervals and checked against an
// interval-based tempo model (last clearing tap time, running period, beat index).
module tb_tap_tempo_detector;

  localparam int DEB = 4;
  localparam int MINP = 20;
  localparam int MAXP = 100;
  localparam int M_IDLE = 0;
  localparam int M_ARMED = 1;
  localparam int M_TRACK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tap_in = 1'b0;
  logic tap_pulse, period_valid, locked;
  logic [31:0] period_out;
  logic [3:0] beat_num;
  logic a, b, c, d, e, f, g;

  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;
  int m_state = M_IDLE;
  longint m_period = 0;
  int m_beat = 0;
  longint m_last_clear = 0;
  bit m_valid = 1'b0;

  tap_tempo_detector #(
    .CLK_HZ(1000), .DEBOUNCE_CYCLES(DEB), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tap_in(tap_in), .tap_pulse(tap_pulse),
    .period_out(period_out), .period_valid(period_valid), .locked(locked),
    .beat_num(beat_num), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int n);
    case (n)
      1: exp_seg = 7'b0110000;
      2: exp_seg = 7'b1101101;
      3: exp_seg = 7'b1111001;
      4: exp_seg = 7'b0110011;
      5: exp_seg = 7'b1011011;
      6: exp_seg = 7'b1011111;
      7: exp_seg = 7'b1110000;
      8: exp_seg = 7'b1111111;
      default: exp_seg = 7'b0000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reference model reaction to an accepted (debounced) tap at time t.
  task automatic model_tap(input longint t);
    longint iv;
    iv = t - m_last_clear;
    m_valid = 1'b0;
    if (m_state != M_IDLE && iv >= MAXP + 2) begin
      m_state = M_IDLE;
      m_beat = 0;
    end
    if (m_state == M_IDLE || iv > MAXP) begin
      m_state = M_ARMED;
      m_beat = 1;
      m_last_clear = t;
    end else if (iv >= MINP) begin
      m_period = (m_state == M_TRACK) ? (m_period + iv) / 2 : iv;
      m_state = M_TRACK;
      m_valid = 1'b1;
      m_beat = (m_beat % 8) + 1;
      m_last_clear = t;
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_period = 0;
    m_beat = 0;
    m_valid = 1'b0;
  endtask

  // One press, then silence until the next tap is due `interval` cycles later.
  task automatic do_tap(input int interval, input string tag);
    int hold;
    hold = (interval / 2 < 8) ? interval / 2 : 8;
    for (int i = 0; i < interval; i++) begin
      tap_in = (i < hold);
      tick();
      if (i == 5) model_tap(cyc);
      n_vec++;
      if (tap_pulse !== (i == 5)) begin
        n_err++;
        $display("FAIL %s tap_pulse it=%0d got %0b exp %0b", tag, i, tap_pulse, (i == 5));
      end
      n_vec++;
      if (period_valid !== ((i == 6) && m_valid)) begin
        n_err++;
        $display("FAIL %s period_valid it=%0d got %0b exp %0b", tag, i, period_valid, ((i == 6) && m_valid));
      end
      if (i == 6) begin
        n_vec++;
        if (locked !== (m_state == M_TRACK) || beat_num !== 4'(m_beat)
            || period_out !== 32'(m_period) || {a, b, c, d, e, f, g} !== exp_seg(m_beat)) begin
          n_err++;
          $display("FAIL %s outputs got locked=%0b beat=%0d period=%0d seg=%b exp locked=%0b beat=%0d period=%0d seg=%b",
                   tag, locked, beat_num, period_out, {a, b, c, d, e, f, g},
                   (m_state == M_TRACK), m_beat, m_period, exp_seg(m_beat));
        end
      end
    end
  endtask

  task automatic wait_quiet(input int n, input string tag);
    tap_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      n_vec++;
      if (tap_pulse !== 1'b0 || period_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s quiet pulses got tap=%0b valid=%0b exp 0 0", tag, tap_pulse, period_valid);
      end
    end
    if (m_state != M_IDLE && cyc - m_last_clear >= MAXP + 3) begin
      m_state = M_IDLE;
      m_beat = 0;
    end
    n_vec++;
    if (locked !== (m_state == M_TRACK) || beat_num !== 4'(m_beat)
        || period_out !== 32'(m_period) || {a, b, c, d, e, f, g} !== exp_seg(m_beat)) begin
      n_err++;
      $display("FAIL %s after-quiet got locked=%0b beat=%0d period=%0d seg=%b exp locked=%0b beat=%0d period=%0d",
               tag, locked, beat_num, period_out, {a, b, c, d, e, f, g},
               (m_state == M_TRACK), m_beat, m_period);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tap_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    model_reset();
    n_vec++;
    if ({tap_pulse, period_valid, locked} !== 3'b000 || period_out !== 32'd0
        || beat_num !== 4'd0 || {a, b, c, d, e, f, g} !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset got pulse=%0b valid=%0b locked=%0b period=%0d beat=%0d seg=%b exp all 0",
               tap_pulse, period_valid, locked, period_out, beat_num, {a, b, c, d, e, f, g});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_taps();
    do_tap(50, "clean1");
    do_tap(50, "clean2");
    do_tap(50, "clean3");
    n_vec++;
    if (period_out !== 32'd50 || locked !== 1'b1 || beat_num !== 4'd3 || {a, b, c, d, e, f, g} !== 7'b1111001) begin
      n_err++;
      $display("FAIL clean_final got period=%0d locked=%0b beat=%0d seg=%b exp 50 1 3 1111001",
               period_out, locked, beat_num, {a, b, c, d, e, f, g});
    end
  endtask

  task automatic test_average();
    wait_quiet(130, "avg_idle");
    do_tap(50, "avg1");
    do_tap(30, "avg2");
    do_tap(20, "avg3");
    n_vec++;
    if (period_out !== 32'd40) begin
      n_err++;
      $display("FAIL average period got %0d exp 40", period_out);
    end
  endtask

  task automatic test_glitch_short();
    wait_quiet(130, "gl_idle");
    for (int i = 0; i < 13; i++) begin
      tap_in = (i < 3);
      tick();
      n_vec++;
      if (tap_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL glitch tap_pulse got %0b exp 0", tap_pulse);
      end
    end
    tap_in = 1'b0;
    do_tap(30, "gl1");
    do_tap(10, "gl2");
    do_tap(40, "gl_short");
    do_tap(20, "gl4");
    n_vec++;
    if (beat_num !== 4'd3 || period_out !== 32'd40) begin
      n_err++;
      $display("FAIL short_ignored got beat=%0d period=%0d exp 3 40", beat_num, period_out);
    end
  endtask

  task automatic test_beat_wrap();
    wait_quiet(130, "wrap_idle");
    for (int i = 0; i < 9; i++) do_tap(25, "wrap");
    n_vec++;
    if (beat_num !== 4'd1 || {a, b, c, d, e, f, g} !== 7'b0110000) begin
      n_err++;
      $display("FAIL wrap got beat=%0d seg=%b exp 1 0110000", beat_num, {a, b, c, d, e, f, g});
    end
    wait_quiet(100, "timeout");
    n_vec++;
    if (locked !== 1'b0 || beat_num !== 4'd0 || {a, b, c, d, e, f, g} !== 7'b0000000 || period_out !== 32'd25) begin
      n_err++;
      $display("FAIL timeout got locked=%0b beat=%0d seg=%b period=%0d exp 0 0 0000000 25",
               locked, beat_num, {a, b, c, d, e, f, g}, period_out);
    end
  endtask

  task automatic test_long_and_bounds();
    wait_quiet(130, "lb_idle");
    do_tap(40, "lb1");
    do_tap(40, "lb2");
    do_tap(150, "lb3");
    do_tap(20, "lb_long150");
    n_vec++;
    if (beat_num !== 4'd1 || locked !== 1'b0 || period_out !== 32'd40) begin
      n_err++;
      $display("FAIL long_interval got beat=%0d locked=%0b period=%0d exp 1 0 40", beat_num, locked, period_out);
    end
    do_tap(100, "b_min");
    do_tap(19, "b_max");
    do_tap(101, "b_short19");
    do_tap(102, "b_long101");
    do_tap(30, "b_long102");
  endtask

  task automatic test_reset_mid();
    do_tap(30, "rm1");
    tap_in = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    tap_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    model_reset();
    n_vec++;
    if ({tap_pulse, period_valid, locked} !== 3'b000 || period_out !== 32'd0
        || beat_num !== 4'd0 || {a, b, c, d, e, f, g} !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset_mid got pulse=%0b valid=%0b locked=%0b period=%0d beat=%0d exp all 0",
               tap_pulse, period_valid, locked, period_out, beat_num);
    end
    rst_n = 1'b1;
    do_tap(40, "rm_after");
    do_tap(40, "rm_next");
  endtask

  task automatic test_random();
    int sel, iv;
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) iv = int'($urandom_range(MINP, MAXP));
      else if (sel < 8) iv = int'($urandom_range(12, MINP - 1));
      else iv = int'($urandom_range(MAXP + 1, 140));
      do_tap(iv, "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean_taps();
    test_average();
    test_glitch_short();
    test_beat_wrap();
    test_long_and_bounds();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tap_tempo_detector.md
TAP_TEMPO_DETECTOR -- requirements
Module: tap_tempo_detector

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz (informational; all timing expressed in clk cycles).
REQ-002 Parameter DEBOUNCE_CYCLES, default 270000, cycles tap level must be stable before acceptance (10 ms).
REQ-003 Parameter MIN_PERIOD, default 6750000, shortest accepted beat interval in cycles (240 BPM).
REQ-004 Parameter MAX_PERIOD, default 54000000, longest accepted beat interval in cycles (30 BPM).
REQ-005 clk  input  1  system clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 tap_in  input  1  raw asynchronous push-button or beat input, active-high.
REQ-008 tap_pulse  output  1  one-cycle pulse per debounced rising edge of tap_in.
REQ-009 period_out  output  32  measured beat period in clk cycles.
REQ-010 period_valid  output  1  one-cycle pulse when period_out updates.
REQ-011 locked  output  1  high while in TRACK state.
REQ-012 beat_num  output  4  current beat index 1..8; 0 = no beat.
REQ-013 a, b, c, d, e, f, g  output  1 each  active-high 7-segment drive showing beat_num.

Function
REQ-014 tap_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current level restarts the count.
REQ-016 tap_pulse SHALL assert for exactly one cycle on the cycle the debounced level goes 0->1; falling edges produce no event.
REQ-017 Interval counter SHALL clear on every tap_pulse, increment each cycle otherwise, and saturate at MAX_PERIOD+1.
REQ-018 Interval of a tap = number of cycles between it and the previous counter-clearing tap_pulse.
REQ-019 States: IDLE, ARMED, TRACK.
REQ-020 IDLE + tap_pulse -> ARMED; beat_num=1; counter cleared.
REQ-021 ARMED + tap with MIN_PERIOD <= interval <= MAX_PERIOD -> TRACK; period_out = interval.
REQ-022 TRACK + in-range tap -> stay TRACK; period_out = floor((period_out + interval)/2), sum computed in 33 bits.
REQ-023 Every in-range tap in ARMED/TRACK: period_valid pulses, beat_num increments, 8 wraps to 1.
REQ-024 period_out, period_valid, beat_num, locked SHALL update on the cycle after the tap_pulse cycle (1-cycle latency).
REQ-025 Tap with interval < MIN_PERIOD SHALL be ignored: no state, counter, beat_num or period change; tap_pulse still asserts.
REQ-026 Tap with interval > MAX_PERIOD in ARMED/TRACK -> ARMED, beat_num=1, counter cleared, period_out retained, no period_valid.
REQ-027 Counter reaching MAX_PERIOD+1 with no tap in ARMED/TRACK -> IDLE, beat_num=0; period_out retained.
REQ-028 Timeout and tap on the same cycle: tap wins, handled per REQ-026.
REQ-029 locked SHALL be 1 exactly while in TRACK.
REQ-030 Segments (abcdefg): 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, all other values 0000000; registered, same latency as beat_num.

Reset
REQ-031 rst_n low at a posedge SHALL set: state IDLE, synchronizer and debounced level 0, debounce and interval counters 0, period_out 0, tap_pulse/period_valid/locked 0, beat_num 0, segments 0000000.
REQ-032 Reset mid-measurement SHALL discard the partial interval; the first tap after release is treated as an IDLE tap.
REQ-033 A tap_in held high through reset release SHALL produce tap_pulse only after DEBOUNCE_CYCLES of stable high.

Verification (DEBOUNCE_CYCLES=4, MIN_PERIOD=20, MAX_PERIOD=100)
REQ-034 Clean taps every 50 cycles x3 -> period_valid twice, period_out 50 then 50, locked=1, beat_num 1,2,3, segments 1111001.
REQ-035 Taps at intervals 50 then 30 -> period_out 50, then floor(80/2)=40.
REQ-036 tap_in glitch high 3 cycles -> no tap_pulse; tap 10 cycles after an accepted tap -> tap_pulse only, state unchanged.
REQ-037 9 in-range taps -> beat_num 1..8 then 1; no tap for 101 cycles -> IDLE, locked=0, beat_num=0, segments 0000000, period_out retained.
REQ-038 Interval 150 while TRACK -> ARMED, beat_num=1, locked=0, no period_valid; rst_n low mid-interval -> all outputs 0 per REQ-031.
